// File: rtl/qdec_ctx_mem_ctrl.sv
// CABAC context-state SRAM arbiter: init FSM passthrough, bin-decoder access,
// and the WPP save (main -> backup) / restore (backup -> main) copy engine.
module qdec_ctx_mem_ctrl #(
   parameter int CTX_NUM = 567,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctx_init_start,
   input  logic [ADDR_W-1:0] ctx_init_addr,
   input  logic [DATA_W-1:0] ctx_init_wdata,
   input  logic              ctx_init_we,
   input  logic              ctx_init_done,
   input  logic              sync_save_start,
   input  logic              sync_rest_start,
   output logic              sync_done,
   input  logic              dec_req,
   input  logic              dec_we,
   input  logic [ADDR_W-1:0] dec_addr,
   input  logic [DATA_W-1:0] dec_wdata,
   output logic              dec_gnt,
   output logic [DATA_W-1:0] dec_rdata,
   output logic              dec_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] bk_addr,
   output logic [DATA_W-1:0] bk_wdata,
   output logic              bk_we,
   input  logic [DATA_W-1:0] bk_rdata,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_SAVE = 2'd2,
      S_REST = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CTX_NUM - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_wr_v;
   logic              r_drain;
   logic              r_sync_done;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic              w_idle;
   logic              w_copy;
   logic              w_any_start;
   logic              w_gnt;

   assign w_idle      = (r_state == S_IDLE);
   assign w_copy      = (r_state == S_SAVE) || (r_state == S_REST);
   assign w_any_start = ctx_init_start | sync_save_start | sync_rest_start;
   assign w_gnt       = dec_req & w_idle & ~w_any_start;

   assign dec_gnt    = w_gnt;
   assign dec_rvalid = r_rvalid;
   assign dec_rdata  = r_rvalid ? mem_rdata : r_rdata;
   assign sync_done  = r_sync_done;
   assign busy       = ~w_idle;
   assign err        = r_err;

   // Next-state selection; start priority in IDLE is init, restore, save.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (ctx_init_start)       w_state_nxt = S_INIT;
            else if (sync_rest_start) w_state_nxt = S_REST;
            else if (sync_save_start) w_state_nxt = S_SAVE;
            else                      w_state_nxt = S_IDLE;
         end
         S_INIT: begin
            if (ctx_init_done) w_state_nxt = S_IDLE;
            else               w_state_nxt = S_INIT;
         end
         S_SAVE, S_REST: begin
            if (r_drain) w_state_nxt = S_IDLE;
            else         w_state_nxt = r_state;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, copy pipeline, read-return and sticky error registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_wr_addr   <= '0;
         r_wr_v      <= 1'b0;
         r_drain     <= 1'b0;
         r_sync_done <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_idle)
            r_cnt <= '0;
         else if (w_copy && (r_cnt != LAST_ADDR))
            r_cnt <= r_cnt + 1'b1;
         // Write stage lags the read address by one cycle (1-cycle SRAM latency).
         r_wr_v      <= w_copy & ~r_drain;
         r_wr_addr   <= r_cnt;
         r_drain     <= w_copy & ~r_drain & (r_cnt == LAST_ADDR);
         r_sync_done <= w_copy & r_drain;
         r_rvalid    <= w_gnt & ~dec_we;
         if (r_rvalid)
            r_rdata <= mem_rdata;
         r_err <= r_err | (w_any_start & ~w_idle) | (ctx_init_we & (r_state != S_INIT));
      end
   end

   // Bank port steering; both ports idle at zero unless an owner drives them.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      bk_addr   = '0;
      bk_wdata  = '0;
      bk_we     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt) begin
               mem_addr  = dec_addr;
               mem_wdata = dec_wdata;
               mem_we    = dec_we;
            end else begin
               mem_we = 1'b0;
            end
         end
         S_INIT: begin
            mem_addr  = ctx_init_addr;
            mem_wdata = ctx_init_wdata;
            mem_we    = ctx_init_we;
         end
         S_SAVE: begin
            if (!r_drain) mem_addr = r_cnt;
            else          mem_addr = '0;
            if (r_wr_v) begin
               bk_we    = 1'b1;
               bk_addr  = r_wr_addr;
               bk_wdata = mem_rdata;
            end else begin
               bk_we = 1'b0;
            end
         end
         S_REST: begin
            if (!r_drain) bk_addr = r_cnt;
            else          bk_addr = '0;
            if (r_wr_v) begin
               mem_we    = 1'b1;
               mem_addr  = r_wr_addr;
               mem_wdata = bk_rdata;
            end else begin
               mem_we = 1'b0;
            end
         end
         default: begin
            mem_we = 1'b0;
            bk_we  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_qdec_ctx_mem_ctrl.sv
// Directed bench for qdec_ctx_mem_ctrl with behavioural models of both SRAM banks.
module tb_qdec_ctx_mem_ctrl;
   localparam int CTX_NUM = 567;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ctx_init_start = 1'b0, ctx_init_we = 1'b0, ctx_init_done = 1'b0;
   logic [ADDR_W-1:0] ctx_init_addr = '0;
   logic [DATA_W-1:0] ctx_init_wdata = '0;
   logic sync_save_start = 1'b0, sync_rest_start = 1'b0, sync_done;
   logic dec_req = 1'b0, dec_we = 1'b0, dec_gnt, dec_rvalid;
   logic [ADDR_W-1:0] dec_addr = '0;
   logic [DATA_W-1:0] dec_wdata = '0, dec_rdata;
   logic [ADDR_W-1:0] mem_addr, bk_addr;
   logic [DATA_W-1:0] mem_wdata, bk_wdata;
   logic [DATA_W-1:0] mem_rdata = '0, bk_rdata = '0;
   logic mem_we, bk_we, busy, err;

   logic [DATA_W-1:0] main_mem [0:1023];
   logic [DATA_W-1:0] bk_mem   [0:1023];
   logic [1:0] pl_main = 2'd0, pl_bk = 2'd0;

   int n_cmp = 0;
   int n_mis = 0;

   qdec_ctx_mem_ctrl #(.CTX_NUM(CTX_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ctx_init_start(ctx_init_start), .ctx_init_addr(ctx_init_addr),
      .ctx_init_wdata(ctx_init_wdata), .ctx_init_we(ctx_init_we),
      .ctx_init_done(ctx_init_done),
      .sync_save_start(sync_save_start), .sync_rest_start(sync_rest_start),
      .sync_done(sync_done),
      .dec_req(dec_req), .dec_we(dec_we), .dec_addr(dec_addr), .dec_wdata(dec_wdata),
      .dec_gnt(dec_gnt), .dec_rdata(dec_rdata), .dec_rvalid(dec_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .bk_addr(bk_addr), .bk_wdata(bk_wdata), .bk_we(bk_we), .bk_rdata(bk_rdata),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(input logic [1:0] mode, input int i);
      case (mode)
         2'd1:    pat = DATA_W'(i % 128);
         2'd2:    pat = 7'h11;
         default: pat = 7'h7F;
      endcase
   endfunction

   // Bank models: synchronous write, 1-cycle read latency, bulk preload hook.
   always @(posedge clk) begin
      if (pl_main != 2'd0) begin
         for (int i = 0; i < CTX_NUM; i++) main_mem[i] <= pat(pl_main, i);
      end else if (mem_we) begin
         main_mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= main_mem[mem_addr];
      if (pl_bk != 2'd0) begin
         for (int i = 0; i < CTX_NUM; i++) bk_mem[i] <= pat(pl_bk, i);
      end else if (bk_we) begin
         bk_mem[bk_addr] <= bk_wdata;
      end
      bk_rdata <= bk_mem[bk_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int ok, nbusy, nwe, ndone, done_at, ngnt;

      // Reset state
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_sync_done", sync_done, 0);
      chk("rst_rvalid", dec_rvalid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_bk_we", bk_we, 0);

      // Init ownership: 567 passthrough writes
      tick();
      ctx_init_start = 1'b1;
      tick();
      ctx_init_start = 1'b0;
      ok = 0;
      for (int i = 0; i < CTX_NUM; i++) begin
         ctx_init_addr  = ADDR_W'(i);
         ctx_init_wdata = DATA_W'(i % 128);
         ctx_init_we    = 1'b1;
         #1;
         if (mem_we === 1'b1 && mem_addr === ADDR_W'(i) && mem_wdata === DATA_W'(i % 128) && busy === 1'b1)
            ok++;
         tick();
      end
      chk("init_we_cycles", ok, CTX_NUM);
      ctx_init_we   = 1'b0;
      ctx_init_done = 1'b1;
      tick();
      ctx_init_done = 1'b0;
      #1;
      chk("init_busy_after_done", busy, 0);
      chk("init_err", err, 0);
      ok = 0;
      for (int i = 0; i < CTX_NUM; i++) if (main_mem[i] === DATA_W'(i % 128)) ok++;
      chk("init_contents", ok, CTX_NUM);

      // Decoder write mem[5]=2A then read it back
      dec_req = 1'b1; dec_we = 1'b1; dec_addr = 10'd5; dec_wdata = 7'h2A;
      #1;
      chk("dec_wr_gnt", dec_gnt, 1);
      chk("dec_wr_mem_we", mem_we, 1);
      tick();
      dec_we = 1'b0;
      #1;
      chk("dec_rd_gnt", dec_gnt, 1);
      chk("dec_rd_addr", mem_addr, 5);
      chk("dec_rd_mem_we", mem_we, 0);
      tick();
      dec_req = 1'b0;
      #1;
      chk("dec_rvalid", dec_rvalid, 1);
      chk("dec_rdata", dec_rdata, 7'h2A);
      tick();
      chk("dec_rvalid_low", dec_rvalid, 0);
      chk("dec_rdata_hold", dec_rdata, 7'h2A);

      // Save: main = i%128, backup pre-filled with 7F
      pl_main = 2'd1; pl_bk = 2'd3;
      tick();
      pl_main = 2'd0; pl_bk = 2'd0;
      sync_save_start = 1'b1;
      tick();
      sync_save_start = 1'b0;
      nbusy = 0; nwe = 0; ndone = 0; done_at = -1;
      for (int c = 0; c < 700; c++) begin
         if (busy) nbusy++;
         if (bk_we) nwe++;
         if (sync_done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         tick();
      end
      chk("save_busy_cycles", nbusy, CTX_NUM + 1);
      chk("save_bk_we_cycles", nwe, CTX_NUM);
      chk("save_done_count", ndone, 1);
      chk("save_done_at", done_at, CTX_NUM + 1);
      chk("save_err", err, 0);
      ok = 0;
      for (int i = 0; i < CTX_NUM; i++) if (bk_mem[i] === DATA_W'(i % 128)) ok++;
      chk("save_contents", ok, CTX_NUM);

      // Restore: backup = 11
      pl_bk = 2'd2;
      tick();
      pl_bk = 2'd0;
      sync_rest_start = 1'b1;
      tick();
      sync_rest_start = 1'b0;
      nwe = 0; ndone = 0;
      for (int c = 0; c < 700; c++) begin
         if (mem_we) nwe++;
         if (sync_done) ndone++;
         tick();
      end
      chk("rest_mem_we_cycles", nwe, CTX_NUM);
      chk("rest_done_count", ndone, 1);
      chk("rest_err", err, 0);
      ok = 0;
      for (int i = 0; i < CTX_NUM; i++) if (main_mem[i] === 7'h11) ok++;
      chk("rest_contents", ok, CTX_NUM);

      // Collision: start beats decoder request; second start during SAVE sets err
      dec_req = 1'b1; dec_we = 1'b0; dec_addr = 10'd3;
      sync_save_start = 1'b1;
      #1;
      chk("coll_gnt_start_cycle", dec_gnt, 0);
      tick();
      chk("coll_busy", busy, 1);
      tick();
      sync_save_start = 1'b0;
      ngnt = 0; ndone = 0;
      for (int c = 0; c < 700 && ndone == 0; c++) begin
         if (sync_done) ndone++;
         else begin
            if (dec_gnt) ngnt++;
            tick();
         end
      end
      chk("coll_done_seen", ndone, 1);
      chk("coll_gnt_during_save", ngnt, 0);
      chk("coll_gnt_after", dec_gnt, 1);
      chk("coll_gnt_addr", mem_addr, 3);
      chk("coll_err", err, 1);
      tick();
      dec_req = 1'b0;

      // Reset mid-save at copy cycle 200
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst2_err_clear", err, 0);
      sync_save_start = 1'b1;
      tick();
      sync_save_start = 1'b0;
      repeat (200) tick();
      chk("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_bk_we", bk_we, 0);
      chk("midrst_sync_done", sync_done, 0);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 600; c++) begin
         if (sync_done) ndone++;
         tick();
      end
      chk("midrst_no_done", ndone, 0);
      dec_req = 1'b1; dec_we = 1'b0; dec_addr = 10'd7;
      #1;
      chk("midrst_gnt", dec_gnt, 1);
      tick();
      dec_req = 1'b0;

      // Init write outside INIT is blocked and flagged
      ctx_init_we = 1'b1; ctx_init_addr = 10'd9; ctx_init_wdata = 7'h55;
      #1;
      chk("stray_we_blocked", mem_we, 0);
      tick();
      ctx_init_we = 1'b0;
      chk("stray_we_err", err, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
